// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths, source encodings and the round-robin pick for the CDB arbiter.
package cdb_arbiter_pkg;
    localparam int ROB_WIDTH_BIT = 4;
    localparam int FIFO_DEPTH_BIT = 1;
    typedef enum logic {CDB_SRC_ALU = 1'b0, CDB_SRC_LSB = 1'b1} cdb_src_t;
    // Only meaningful when at least one candidate is present; ties go to the source not granted last.
    function automatic cdb_src_t rr_pick(logic alu_c, logic lsb_c, cdb_src_t last);
        return (alu_c && (!lsb_c || last == CDB_SRC_LSB)) ? CDB_SRC_ALU : CDB_SRC_LSB;
    endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: ALU/LSB result handshakes and the registered CDB broadcast.
interface cdb_arbiter_if #(
    parameter int ROB_WIDTH_BIT = cdb_arbiter_pkg::ROB_WIDTH_BIT
);
    logic alu_valid, alu_ready, lsb_valid, lsb_ready, cdb_valid;
    logic [ROB_WIDTH_BIT-1:0] alu_rob_id, lsb_rob_id, cdb_rob_id;
    logic [31:0] alu_val, lsb_val, cdb_val;
    modport slave (
        input  alu_valid, alu_rob_id, alu_val, lsb_valid, lsb_rob_id, lsb_val,
        output alu_ready, lsb_ready, cdb_valid, cdb_rob_id, cdb_val
    );
    modport master (
        output alu_valid, alu_rob_id, alu_val, lsb_valid, lsb_rob_id, lsb_val,
        input  alu_ready, lsb_ready, cdb_valid, cdb_rob_id, cdb_val
    );
endinterface

// File: rtl/cdb_arbiter_wb_fifo.sv
// wb_fifo: small circular FIFO holding one source's completed results until granted.
module wb_fifo #(
    parameter int DATA_WIDTH = 36,
    parameter int DEPTH_BIT = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);
    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam int CW = DEPTH_BIT + 1;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    assign empty = cnt_q == '0;
    assign full = cnt_q == CW'(DEPTH);
    assign dout = mem_q[rd_ptr_q];
    always_comb begin
        mem_d = mem_q;
        if (rdy_in && !flush && push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = !rdy_in ? wr_ptr_q : flush ? '0 : wr_ptr_q + DEPTH_BIT'(push);
        rd_ptr_d = !rdy_in ? rd_ptr_q : flush ? '0 : rd_ptr_q + DEPTH_BIT'(pop);
        cnt_d = !rdy_in ? cnt_q : flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_q <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers ALU and LSB results per source and broadcasts one per cycle on the CDB,
// round-robin between the two sources.
module cdb_arbiter #(
    parameter int ROB_WIDTH_BIT = cdb_arbiter_pkg::ROB_WIDTH_BIT,
    parameter int FIFO_DEPTH_BIT = cdb_arbiter_pkg::FIFO_DEPTH_BIT
) (
    input logic          clk_in,
    input logic          rst_in,
    input logic          rdy_in,
    input logic          clear,
    cdb_arbiter_if.slave bus
);
    import cdb_arbiter_pkg::*;
    localparam int DW = ROB_WIDTH_BIT + 32;
    logic alu_full, alu_empty, lsb_full, lsb_empty, grant, alu_push, lsb_push, alu_pop, lsb_pop;
    logic [DW-1:0] alu_head, lsb_head;
    cdb_src_t win, last_grant_q, last_grant_d;
    logic cdb_valid_q, cdb_valid_d;
    logic [ROB_WIDTH_BIT-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [31:0] cdb_val_q, cdb_val_d;
    assign bus.alu_ready = rdy_in && !alu_full;
    assign bus.lsb_ready = rdy_in && !lsb_full;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_rob_id = cdb_rob_id_q;
    assign bus.cdb_val = cdb_val_q;
    assign alu_push = bus.alu_valid && bus.alu_ready;
    assign lsb_push = bus.lsb_valid && bus.lsb_ready;
    assign grant = rdy_in && !clear && !(alu_empty && lsb_empty);
    assign win = rr_pick(!alu_empty, !lsb_empty, last_grant_q);
    assign alu_pop = grant && win == CDB_SRC_ALU;
    assign lsb_pop = grant && win == CDB_SRC_LSB;
    wb_fifo #(.DATA_WIDTH(DW), .DEPTH_BIT(FIFO_DEPTH_BIT)) u_alu_fifo (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(clear),
        .push(alu_push), .pop(alu_pop), .din({bus.alu_rob_id, bus.alu_val}),
        .dout(alu_head), .empty(alu_empty), .full(alu_full)
    );
    wb_fifo #(.DATA_WIDTH(DW), .DEPTH_BIT(FIFO_DEPTH_BIT)) u_lsb_fifo (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(clear),
        .push(lsb_push), .pop(lsb_pop), .din({bus.lsb_rob_id, bus.lsb_val}),
        .dout(lsb_head), .empty(lsb_empty), .full(lsb_full)
    );
    // Tag/value hold their last broadcast when nothing is granted, including on clear.
    always_comb begin
        last_grant_d = !rdy_in ? last_grant_q : clear ? CDB_SRC_LSB : grant ? win : last_grant_q;
        cdb_valid_d = rdy_in ? grant : cdb_valid_q;
        {cdb_rob_id_d, cdb_val_d} = !grant ? {cdb_rob_id_q, cdb_val_q} : alu_pop ? alu_head : lsb_head;
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_grant_q <= CDB_SRC_LSB;
            cdb_valid_q <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_val_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_val_q <= cdb_val_d;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table, hand sequences for backpressure and async reset,
// and randomized traffic checked against a queue-based model of the arbiter rules.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;
    localparam int RW = ROB_WIDTH_BIT;
    logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, clr = 1'b0;
    always #5 clk = ~clk;
    cdb_arbiter_if bus();
    cdb_arbiter dut (.clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clr), .bus(bus));
    int n_pass = 0, n_tot = 0;
    typedef struct {
        bit r, c, av;
        logic [RW-1:0] aid;
        logic [31:0] aval;
        bit lv;
        logic [RW-1:0] lid;
        logic [31:0] lval;
        bit ar, lr, cv;
        logic [RW-1:0] cid;
        logic [31:0] cval;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t row(bit r, bit c, bit av, logic [RW-1:0] aid, logic [31:0] aval,
                                 bit lv, logic [RW-1:0] lid, logic [31:0] lval,
                                 bit ar, bit lr, bit cv, logic [RW-1:0] cid, logic [31:0] cval);
        vec_t v;
        v.r = r; v.c = c; v.av = av; v.aid = aid; v.aval = aval;
        v.lv = lv; v.lid = lid; v.lval = lval;
        v.ar = ar; v.lr = lr; v.cv = cv; v.cid = cid; v.cval = cval;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(bit r, bit c, bit av, logic [RW-1:0] aid, logic [31:0] aval,
                         bit lv, logic [RW-1:0] lid, logic [31:0] lval);
        rdy = r; clr = c;
        bus.alu_valid = av; bus.alu_rob_id = aid; bus.alu_val = aval;
        bus.lsb_valid = lv; bus.lsb_rob_id = lid; bus.lsb_val = lval;
    endtask

    task automatic chk_cdb(string nm, bit cv, logic [RW-1:0] cid, logic [31:0] cval);
        chk({nm, " cdb_valid"}, 64'(bus.cdb_valid), 64'(cv));
        chk({nm, " cdb_rob_id"}, 64'(bus.cdb_rob_id), 64'(cid));
        chk({nm, " cdb_val"}, 64'(bus.cdb_val), 64'(cval));
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference: two bounded queues, a last-grant flag and a registered broadcast.
    task automatic run_model(int n, int pv, int pr, int pc);
        logic [RW+31:0] qa[$], ql[$];
        logic [RW+31:0] h;
        bit a_v = 0, l_v = 0, last_lsb = 1, cv = 0, r, c, acc_a, acc_l, ga, gl;
        logic [RW-1:0] a_id = '0, l_id = '0, cid = '0;
        logic [31:0] a_val = '0, l_val = '0, cval = '0;
        int seq = 0;
        for (int k = 0; k < n; k++) begin
            if (!a_v && $urandom_range(99) < pv) begin
                a_v = 1; a_id = RW'($urandom); a_val = 32'hA000_0000 | seq; seq++;
            end
            if (!l_v && $urandom_range(99) < pv) begin
                l_v = 1; l_id = RW'($urandom); l_val = 32'hB000_0000 | seq; seq++;
            end
            r = $urandom_range(99) < pr;
            c = $urandom_range(99) < pc;
            drive(r, c, a_v, a_id, a_val, l_v, l_id, l_val);
            #1;
            chk("rnd alu_ready", 64'(bus.alu_ready), 64'(r && qa.size() < 2));
            chk("rnd lsb_ready", 64'(bus.lsb_ready), 64'(r && ql.size() < 2));
            acc_a = r && a_v && qa.size() < 2;
            acc_l = r && l_v && ql.size() < 2;
            if (r && c) begin
                qa.delete(); ql.delete(); last_lsb = 1; cv = 0;
            end else if (r) begin
                ga = qa.size() > 0 && (ql.size() == 0 || last_lsb);
                gl = ql.size() > 0 && !ga;
                cv = ga || gl;
                if (ga) begin h = qa.pop_front(); last_lsb = 0; end
                if (gl) begin h = ql.pop_front(); last_lsb = 1; end
                if (cv) {cid, cval} = h;
                if (acc_a) qa.push_back({a_id, a_val});
                if (acc_l) ql.push_back({l_id, l_val});
            end
            if (acc_a) a_v = 0;
            if (acc_l) l_v = 0;
            @(negedge clk);
            chk_cdb("rnd", cv, cid, cval);
        end
    endtask

    initial begin
        tbl.push_back(row(1,0, 1,1,32'hA,   1,2,32'hB,   1,1, 0,0,32'h0));
        tbl.push_back(row(1,0, 0,0,0,       0,0,0,       1,1, 1,1,32'hA));
        tbl.push_back(row(1,0, 0,0,0,       0,0,0,       1,1, 1,2,32'hB));
        tbl.push_back(row(1,0, 0,0,0,       0,0,0,       1,1, 0,2,32'hB));
        tbl.push_back(row(1,0, 1,3,32'h11,  0,0,0,       1,1, 0,2,32'hB));
        tbl.push_back(row(1,0, 0,0,0,       0,0,0,       1,1, 1,3,32'h11));
        tbl.push_back(row(1,0, 0,0,0,       0,0,0,       1,1, 0,3,32'h11));
        tbl.push_back(row(1,0, 1,5,32'h55,  1,6,32'h66,  1,1, 0,3,32'h11));
        tbl.push_back(row(0,0, 0,0,0,       0,0,0,       0,0, 0,3,32'h11));
        tbl.push_back(row(1,0, 0,0,0,       0,0,0,       1,1, 1,6,32'h66));
        tbl.push_back(row(0,0, 0,0,0,       0,0,0,       0,0, 1,6,32'h66));
        tbl.push_back(row(0,0, 0,0,0,       0,0,0,       0,0, 1,6,32'h66));
        tbl.push_back(row(0,0, 0,0,0,       0,0,0,       0,0, 1,6,32'h66));
        tbl.push_back(row(1,0, 0,0,0,       0,0,0,       1,1, 1,5,32'h55));
        tbl.push_back(row(1,0, 0,0,0,       0,0,0,       1,1, 0,5,32'h55));
        tbl.push_back(row(1,0, 1,7,32'h77,  1,8,32'h88,  1,1, 0,5,32'h55));
        tbl.push_back(row(1,0, 1,11,32'hBB, 1,12,32'hCC, 1,1, 1,8,32'h88));
        tbl.push_back(row(1,1, 1,9,32'h99,  1,10,32'hAA, 0,1, 0,8,32'h88));
        tbl.push_back(row(1,0, 0,0,0,       0,0,0,       1,1, 0,8,32'h88));
        tbl.push_back(row(1,0, 0,0,0,       0,0,0,       1,1, 0,8,32'h88));
        tbl.push_back(row(1,0, 1,1,32'h1,   1,2,32'h2,   1,1, 0,8,32'h88));
        tbl.push_back(row(1,0, 0,0,0,       0,0,0,       1,1, 1,1,32'h1));
        tbl.push_back(row(1,0, 0,0,0,       0,0,0,       1,1, 1,2,32'h2));
        tbl.push_back(row(1,0, 0,0,0,       0,0,0,       1,1, 0,2,32'h2));

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_cdb("reset", 0, 0, 0);
        chk("reset alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("reset lsb_ready", 64'(bus.lsb_ready), 64'd1);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].c, tbl[i].av, tbl[i].aid, tbl[i].aval,
                  tbl[i].lv, tbl[i].lid, tbl[i].lval);
            #1;
            chk($sformatf("vec%0d alu_ready", i), 64'(bus.alu_ready), 64'(tbl[i].ar));
            chk($sformatf("vec%0d lsb_ready", i), 64'(bus.lsb_ready), 64'(tbl[i].lr));
            @(negedge clk);
            chk_cdb($sformatf("vec%0d", i), tbl[i].cv, tbl[i].cid, tbl[i].cval);
        end

        // Continuous offers from both sources fill the LSB FIFO on the third cycle.
        do_reset();
        drive(1, 0, 1, 1, 32'h1, 1, 2, 32'h2);
        #1 chk("bp c0 lsb_ready", 64'(bus.lsb_ready), 64'd1);
        @(negedge clk);
        drive(1, 0, 1, 3, 32'h3, 1, 4, 32'h4);
        #1 chk("bp c1 lsb_ready", 64'(bus.lsb_ready), 64'd1);
        @(negedge clk);
        chk_cdb("bp c1", 1, 1, 32'h1);
        #1;
        chk("bp c2 lsb_ready", 64'(bus.lsb_ready), 64'd0);
        chk("bp c2 alu_ready", 64'(bus.alu_ready), 64'd1);

        // Asynchronous reset between edges with queued entries.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk_cdb("async rst", 0, 0, 0);
        chk("async rst alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("async rst lsb_ready", 64'(bus.lsb_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 1, 5, 32'h5, 1, 6, 32'h6);
        @(negedge clk);
        chk_cdb("post rst push", 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_cdb("post rst tie alu", 1, 5, 32'h5);
        @(negedge clk);
        chk_cdb("post rst tie lsb", 1, 6, 32'h6);

        do_reset();
        run_model(400, 70, 85, 3);
        do_reset();
        run_model(200, 100, 100, 0);
        do_reset();
        run_model(300, 50, 70, 6);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
